usb_tx_encoder: RTL
===================

USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

Interface
REQ-001 SHALL provide parameter: CLKS_PER_BIT, 8, clk cycles per USB bit period (>=4).
REQ-002 SHALL provide: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL provide: n_rst  input  1  asynchronous active-low reset.
REQ-004 SHALL provide: tx_valid  input  1  tx_data/tx_last valid this cycle.
REQ-005 SHALL provide: tx_data  input  8  packet byte, sent LSB first.
REQ-006 SHALL provide: tx_last  input  1  accompanying byte is final byte of packet.
REQ-007 SHALL provide: tx_ready  output  1  holding register empty; byte accepted when tx_valid && tx_ready.
REQ-008 SHALL provide: tx_busy  output  1  packet in progress (any state but IDLE).
REQ-009 SHALL provide: tx_error  output  1  one-cycle pulse on underrun abort.
REQ-010 SHALL provide: dplus_out, dminus_out  output  1 each  line drive; J = (1,0), K = (0,1), SE0 = (0,0).

Function
REQ-011 SHALL buffer input as 1-byte holding register + 8-bit shift register; tx_ready = ~hold_full.
REQ-012 SHALL move holding to shift register at each byte boundary (last clk of bit 7 period, incl. any trailing stuff bit); acceptance and transfer in the same cycle are legal.
REQ-013 SHALL use states IDLE, SYNC, DATA, EOP; IDLE->SYNC on cycle after first accept; SYNC->DATA after 8 bit periods; DATA->EOP after last byte's final bit (and stuff bit, if due); EOP->IDLE after 3 bit periods.
REQ-014 SHALL hold each transmitted bit exactly CLKS_PER_BIT cycles via bit-period counter cleared on every state entry.
REQ-015 SHALL NRZI-encode: data 0 toggles J/K, data 1 holds; line is J on entry to SYNC.
REQ-016 SHALL count consecutive transmitted 1s from SYNC start; after six 1s, insert one 0 bit period (toggle) before next data bit; counter clears on any 0 or stuff bit.
REQ-017 SHALL insert a stuff bit after the sixth 1 even when it is the last data bit of the packet, before EOP.
REQ-018 SHALL drive EOP as SE0 for 2 bit periods, then J for 1 bit period.
REQ-019 SHALL, at a DATA byte boundary with holding register empty and no tx_last byte sent, pulse tx_error 1 cycle and enter EOP immediately.
REQ-020 SHALL ignore tx_valid while tx_ready low; tx_last on non-final byte is honoured as end.
REQ-021 SHALL drive J in IDLE; tx_busy high from SYNC entry through final J bit of EOP.

Reset
REQ-022 SHALL on n_rst low asynchronously: state IDLE, dplus_out=1, dminus_out=0, tx_ready=1, tx_busy=0, tx_error=0, counters and ones count 0, holding empty.
REQ-023 SHALL abandon any packet on reset mid-operation with no EOP; line returns to J immediately.

Configuration
REQ-024 SHALL with USB_TX_SYNC_GEN_EN defined, auto-generate SYNC (0x80, LSB first: KJKJKJKK) in SYNC state.
REQ-025 SHALL without USB_TX_SYNC_GEN_EN, omit SYNC state (IDLE->DATA directly); user supplies 0x80 as first byte; stuff counter starts at 0 on DATA entry.

Verification (CLKS_PER_BIT=8, USB_TX_SYNC_GEN_EN defined)
REQ-026 SHALL cover: single byte 0x00 tx_last=1 -> SYNC KJKJKJKK, data JKJKJKJK, SE0 16 clks, J 8 clks; tx_busy high 19x8=152 clks.
REQ-027 SHALL cover: byte 0xFF last -> after SYNC (ends with one 1), 5 data 1s then stuff toggle, 3 remaining 1s; 9 data bit periods total.
REQ-028 SHALL cover: bytes 0x3F,0x00 back-to-back with tx_valid held -> stuff bit after bit 4 of 0x3F, no gaps, tx_ready re-asserts each transfer.
REQ-029 SHALL cover: byte 0xA5 without tx_last, no further valid -> tx_error pulse at end of byte, SE0 SE0 J, IDLE, tx_ready=1.
REQ-030 SHALL cover: n_rst low mid-DATA -> same cycle dplus_out=1, dminus_out=0, tx_busy=0; next packet starts clean with SYNC.
REQ-031 SHALL cover: macro undefined, bytes 0x80,0x2D last -> wire identical to macro-defined single byte 0x2D.

Source files
------------

// File: rtl/usb_tx_encoder.sv
// rtl/usb_tx_encoder.sv - USB transmit encoder: NRZI, bit stuffing, SYNC/EOP framing (optional macro USB_TX_SYNC_GEN_EN)
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_error,
  output logic       dplus_out,
  output logic       dminus_out
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
`ifdef USB_TX_SYNC_GEN_EN
  localparam logic [7:0] SYNC_BYTE = 8'h80;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    EOP  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    ones_cnt;
  logic          stuffing;
  logic [7:0]    shift_data;
  logic          shift_last;
  logic [7:0]    hold_data;
  logic          hold_last;
  logic          hold_full;

  logic          accept;
  logic          bit_end;
  logic          stuff_due;
  logic          byte_end;
  logic          boundary;
  logic          have_next;
  logic [7:0]    next_byte;
  logic          next_last;
  logic          next_bit;
  logic          hold_load;
  logic          hold_take;

  assign tx_ready = ~hold_full;
  assign tx_busy  = (state != IDLE);

  // Decode next bit value, next byte source and holding register moves
  always_comb begin
    accept    = tx_valid && !hold_full;
    bit_end   = (clk_cnt == CNT_LAST);
    stuff_due = !stuffing && (ones_cnt == 3'd6);
    byte_end  = (bit_idx == 3'd7) && !stuff_due;
    have_next = hold_full || accept;
    next_byte = hold_full ? hold_data : tx_data;
    next_last = hold_full ? hold_last : tx_last;
    boundary  = bit_end && byte_end &&
                ((state == SYNC) || ((state == DATA) && !shift_last));

    // A byte arriving exactly at a boundary with the holding register empty
    // bypasses the holding register and goes straight into the shifter.
    hold_load = accept;
    hold_take = 1'b0;
    if (boundary) begin
      hold_load = 1'b0;
      hold_take = hold_full;
    end
`ifndef USB_TX_SYNC_GEN_EN
    if (state == IDLE) begin
      hold_load = 1'b0;
      hold_take = hold_full;
    end
`endif

    next_bit = 1'b0;
    case (state)
`ifdef USB_TX_SYNC_GEN_EN
      IDLE:    next_bit = SYNC_BYTE[0];
      SYNC:    next_bit = (bit_idx == 3'd7) ? next_byte[0] : SYNC_BYTE[bit_idx + 3'd1];
`else
      IDLE:    next_bit = next_byte[0];
`endif
      DATA:    next_bit = (bit_idx == 3'd7) ? next_byte[0] : shift_data[bit_idx + 3'd1];
      default: next_bit = 1'b0;
    endcase
  end

  // Framing FSM, bit timing, NRZI line drive and byte buffering
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      ones_cnt   <= '0;
      stuffing   <= 1'b0;
      shift_data <= '0;
      shift_last <= 1'b0;
      hold_data  <= '0;
      hold_last  <= 1'b0;
      hold_full  <= 1'b0;
      tx_error   <= 1'b0;
      dplus_out  <= 1'b1;
      dminus_out <= 1'b0;
    end else begin
      tx_error <= 1'b0;

      if (hold_load) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
        hold_last <= tx_last;
      end else if (hold_take) begin
        hold_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          clk_cnt    <= '0;
          bit_idx    <= '0;
          ones_cnt   <= '0;
          stuffing   <= 1'b0;
          dplus_out  <= 1'b1;
          dminus_out <= 1'b0;
          if (have_next) begin
`ifdef USB_TX_SYNC_GEN_EN
            state <= SYNC;
`else
            state      <= DATA;
            shift_data <= next_byte;
            shift_last <= next_last;
`endif
            // Line is J here, so the first bit is encoded relative to J
            if (next_bit) begin
              ones_cnt <= 3'd1;
            end else begin
              dplus_out  <= 1'b0;
              dminus_out <= 1'b1;
            end
          end
        end

`ifdef USB_TX_SYNC_GEN_EN
        SYNC: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state      <= DATA;
              shift_data <= next_byte;
              shift_last <= next_last;
            end
            if (next_bit) begin
              ones_cnt <= ones_cnt + 3'd1;
            end else begin
              ones_cnt   <= '0;
              dplus_out  <= ~dplus_out;
              dminus_out <= ~dminus_out;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
`endif

        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (stuff_due) begin
              // Sixth consecutive 1 just went out: insert a forced transition
              stuffing   <= 1'b1;
              ones_cnt   <= '0;
              dplus_out  <= ~dplus_out;
              dminus_out <= ~dminus_out;
            end else if (byte_end && (shift_last || !have_next)) begin
              // Normal end of packet, or underrun abort when nothing follows
              state      <= EOP;
              bit_idx    <= '0;
              ones_cnt   <= '0;
              stuffing   <= 1'b0;
              dplus_out  <= 1'b0;
              dminus_out <= 1'b0;
              tx_error   <= !shift_last;
            end else begin
              stuffing <= 1'b0;
              bit_idx  <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
                shift_data <= next_byte;
                shift_last <= next_last;
              end
              if (next_bit) begin
                ones_cnt <= ones_cnt + 3'd1;
              end else begin
                ones_cnt   <= '0;
                dplus_out  <= ~dplus_out;
                dminus_out <= ~dminus_out;
              end
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        EOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd2) begin
              state      <= IDLE;
              bit_idx    <= '0;
              dplus_out  <= 1'b1;
              dminus_out <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              // Two SE0 periods, then one J period
              if (bit_idx == 3'd1) begin
                dplus_out  <= 1'b1;
                dminus_out <= 1'b0;
              end
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
